// File: rtl/cld_pkg.sv
// Shared definitions for the pulse-timer slice: FSM encodings and sizing helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cld_pkg;

    // Timer FSM encodings; the values are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] RUN_ENC   = 2'd1;
    localparam logic [1:0] PAUSE_ENC = 2'd2;

    // Bits needed to hold 0..p-1, never less than one.
    function automatic int presc_width(input int p);
        int w;
        w = $clog2(p);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/m_prescaler.sv
// Free-running divider 0..PRESCALE-1 used as the count-tick source of the timer.
// Latency: r_tick is registered and is high while the counter sits on PRESCALE-1.
// Backpressure: none; w_en freezes the counter in place, w_clr returns it to 0.
module m_prescaler
    import cld_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic w_clk,
    input  logic w_rst,
    input  logic w_en,
    input  logic w_clr,
    output logic r_tick
);

    localparam int CW = presc_width(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Next value of the divider, wrapping after the last count.
    always_comb begin
        cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    // Divider register plus a flag marking "the next enabled edge is the wrap".
    // Exposing the flag lets the parent act on the very edge the wrap happens.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            cnt    <= '0;
            r_tick <= 1'b0;
        end else if (w_clr) begin
            cnt    <= '0;
            r_tick <= 1'b0;
        end else if (w_en) begin
            cnt    <= cnt_nxt;
            r_tick <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/m_pulse_timer.sv
// Down-counting pulse timer with pause/resume/abort and optional auto-reload.
// Latency: r_done rises N*PRESCALE cycles after the start edge for load value N.
// Backpressure: none; w_stop pauses (RUN) or aborts (PAUSE), w_start in RUN is ignored.
module m_pulse_timer
    import cld_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_start,
    input  logic             w_stop,
    input  logic             w_auto,
    input  logic [WIDTH-1:0] w_load_val,
    output logic [WIDTH-1:0] r_count,
    output logic             r_busy,
    output logic             r_tick,
    output logic             r_done
);

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic             auto_flag;

    logic ps_last;
    logic ps_en;
    logic ps_clr;
    logic running;
    logic tick_evt;

    assign running  = (state == ST_RUN);
    // A count tick is the edge on which the prescaler wraps while running.
    assign tick_evt = running && ps_last;
    // A stop freezes the prescaler, except when it coincides with the wrap:
    // that tick is still taken so the decrement lands before pausing.
    assign ps_en    = running && (!w_stop || ps_last);
    // Held at zero while idle so every fresh start begins a full period.
    assign ps_clr   = (state == ST_IDLE);
    // Decoded only from the state register, so no input reaches it.
    assign r_busy   = (state != ST_IDLE);

    m_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .w_clk  (w_clk),
        .w_rst  (w_rst),
        .w_en   (ps_en),
        .w_clr  (ps_clr),
        .r_tick (ps_last)
    );

    // Timer FSM with registered count, tick and done outputs.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state     <= ST_IDLE;
            r_count   <= '0;
            reload    <= '0;
            auto_flag <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tick <= tick_evt;
            r_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Start together with stop is ignored while idle.
                    if (w_start && !w_stop) begin
                        if (w_load_val != '0) begin
                            r_count   <= w_load_val;
                            reload    <= w_load_val;
                            auto_flag <= w_auto;
                            state     <= ST_RUN;
                        end else begin
                            // Zero-length timer completes immediately.
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick_evt) begin
                        if (r_count == WIDTH'(1)) begin
                            r_done <= 1'b1;
                            if (auto_flag) begin
                                r_count <= reload;
                                state   <= w_stop ? ST_PAUSE : ST_RUN;
                            end else begin
                                r_count <= '0;
                                state   <= ST_IDLE;
                            end
                        end else begin
                            // Saturate at zero rather than wrap.
                            if (r_count != '0) begin
                                r_count <= r_count - WIDTH'(1);
                            end
                            state <= w_stop ? ST_PAUSE : ST_RUN;
                        end
                    end else if (w_stop) begin
                        state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    // Stop wins over start: abort without a done pulse.
                    if (w_stop) begin
                        r_count <= '0;
                        state   <= ST_IDLE;
                    end else if (w_start) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_pulse_timer.sv
// Scoreboard bench for m_pulse_timer: expected tick/done events are queued by the
// stimulus and matched by an independent monitor on every tick or done pulse.
// Cycle numbers are posedge counts; outputs are sampled on the falling edge.
module tb_m_pulse_timer;

    logic       w_clk;
    logic       w_rst;
    logic       w_start;
    logic       w_stop;
    logic       w_auto;
    logic [7:0] w_load_val;
    logic [7:0] r_count;
    logic       r_busy;
    logic       r_tick;
    logic       r_done;

    m_pulse_timer #(
        .WIDTH    (8),
        .PRESCALE (4)
    ) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_start    (w_start),
        .w_stop     (w_stop),
        .w_auto     (w_auto),
        .w_load_val (w_load_val),
        .r_count    (r_count),
        .r_busy     (r_busy),
        .r_tick     (r_tick),
        .r_done     (r_done)
    );

    typedef struct {
        int         edge_n;
        logic       tick;
        logic       done;
        logic [7:0] count;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  cyc       = 0;
    int  pass_cnt  = 0;
    int  total_cnt = 0;

    initial w_clk = 1'b0;
    always #50 w_clk = ~w_clk;

    always @(posedge w_clk) cyc <= cyc + 1;

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: run did not finish, cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // Monitor: every tick/done pulse must match the next queued expectation.
    always @(negedge w_clk) begin
        if (!w_rst && (r_tick || r_done)) begin
            total_cnt = total_cnt + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: cyc=%0d tick=%0b done=%0b count=%0d, required no event",
                         cyc, r_tick, r_done, r_count);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc == mon_e.edge_n && r_tick === mon_e.tick &&
                    r_done === mon_e.done && r_count === mon_e.count) begin
                    pass_cnt = pass_cnt + 1;
                end else begin
                    $display("FAIL event: got cyc=%0d tick=%0b done=%0b count=%0d, required cyc=%0d tick=%0b done=%0b count=%0d",
                             cyc, r_tick, r_done, r_count,
                             mon_e.edge_n, mon_e.tick, mon_e.done, mon_e.count);
                end
            end
        end
    end

    task automatic push(input int e, input logic t, input logic d, input logic [7:0] c);
        ev_t ev;
        ev.edge_n = e;
        ev.tick   = t;
        ev.done   = d;
        ev.count  = c;
        exp_q.push_back(ev);
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        total_cnt = total_cnt + 1;
        if (act == exp_v) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got %0d, required %0d (cyc=%0d)", name, act, exp_v, cyc);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge w_clk);
    endtask

    // Each pulse task is entered on a falling edge; the DUT samples the
    // pulse on the next rising edge and the task returns on the falling edge after.
    task automatic do_start(input logic [7:0] v, input logic a);
        w_load_val = v;
        w_auto     = a;
        w_start    = 1'b1;
        @(negedge w_clk);
        w_start    = 1'b0;
    endtask

    task automatic do_stop();
        w_stop = 1'b1;
        @(negedge w_clk);
        w_stop = 1'b0;
    endtask

    task automatic do_both();
        w_start = 1'b1;
        w_stop  = 1'b1;
        @(negedge w_clk);
        w_start = 1'b0;
        w_stop  = 1'b0;
    endtask

    int t0;

    initial begin
        w_rst      = 1'b1;
        w_start    = 1'b0;
        w_stop     = 1'b0;
        w_auto     = 1'b0;
        w_load_val = 8'd0;
        repeat (3) @(negedge w_clk);
        chk("reset_count", r_count, 0);
        chk("reset_busy",  r_busy,  0);
        chk("reset_tick",  r_tick,  0);
        chk("reset_done",  r_done,  0);
        w_rst = 1'b0;
        repeat (2) @(negedge w_clk);

        // Load 3, no auto: ticks at +4,+8,+12, done at +12, then idle.
        t0 = cyc + 1;
        push(t0 + 4,  1, 0, 8'd2);
        push(t0 + 8,  1, 0, 8'd1);
        push(t0 + 12, 1, 1, 8'd0);
        do_start(8'd3, 1'b0);
        chk("basic_loaded",  r_count, 3);
        chk("basic_busy",    r_busy,  1);
        wait_until(t0 + 13);
        chk("basic_idle",    r_busy,  0);
        chk("basic_count0",  r_count, 0);
        repeat (3) @(negedge w_clk);

        // Load 2, auto: done every 8 cycles with reload; ignored start/load change.
        t0 = cyc + 1;
        push(t0 + 4,  1, 0, 8'd1);
        push(t0 + 8,  1, 1, 8'd2);
        push(t0 + 12, 1, 0, 8'd1);
        push(t0 + 16, 1, 1, 8'd2);
        push(t0 + 20, 1, 0, 8'd1);
        push(t0 + 24, 1, 1, 8'd2);
        do_start(8'd2, 1'b1);
        wait_until(t0 + 1);
        do_start(8'd9, 1'b0);
        wait_until(t0 + 25);
        chk("auto_busy",       r_busy,  1);
        chk("auto_reloaded",   r_count, 2);
        do_stop();
        chk("auto_paused",     r_busy,  1);
        wait_until(t0 + 30);
        chk("auto_hold_count", r_count, 2);
        do_stop();
        chk("abort_idle",      r_busy,  0);
        chk("abort_count0",    r_count, 0);
        repeat (3) @(negedge w_clk);

        // Load 5, stop at +6, resume at +16: done at +31.
        t0 = cyc + 1;
        push(t0 + 4,  1, 0, 8'd4);
        push(t0 + 19, 1, 0, 8'd3);
        push(t0 + 23, 1, 0, 8'd2);
        push(t0 + 27, 1, 0, 8'd1);
        push(t0 + 31, 1, 1, 8'd0);
        do_start(8'd5, 1'b0);
        wait_until(t0 + 5);
        do_stop();
        chk("pause_count",     r_count, 4);
        wait_until(t0 + 15);
        chk("pause_frozen",    r_count, 4);
        chk("pause_busy",      r_busy,  1);
        do_start(8'd5, 1'b0);
        wait_until(t0 + 32);
        chk("resume_idle",     r_busy,  0);
        repeat (3) @(negedge w_clk);

        // Load 0: immediate done, never busy.
        t0 = cyc + 1;
        push(t0, 0, 1, 8'd0);
        do_start(8'd0, 1'b0);
        chk("zero_busy", r_busy, 0);
        @(negedge w_clk);
        chk("zero_busy_after", r_busy, 0);
        repeat (3) @(negedge w_clk);

        // Start+stop together: RUN -> PAUSE, PAUSE -> IDLE, IDLE ignores both.
        t0 = cyc + 1;
        do_start(8'd3, 1'b0);
        do_both();
        chk("both_run_pause", r_busy,  1);
        chk("both_run_count", r_count, 3);
        wait_until(t0 + 5);
        do_both();
        chk("both_pause_idle",  r_busy,  0);
        chk("both_pause_count", r_count, 0);
        w_load_val = 8'd4;
        do_both();
        chk("both_idle_ignored", r_busy, 0);
        repeat (3) @(negedge w_clk);

        // Stop on the tick edge: decrement lands, then PAUSE; resume finishes.
        t0 = cyc + 1;
        push(t0 + 4,  1, 0, 8'd1);
        push(t0 + 11, 1, 1, 8'd0);
        do_start(8'd2, 1'b0);
        wait_until(t0 + 3);
        do_stop();
        chk("tickstop_busy",  r_busy,  1);
        chk("tickstop_count", r_count, 1);
        wait_until(t0 + 6);
        do_start(8'd2, 1'b0);
        wait_until(t0 + 12);
        chk("tickstop_idle",  r_busy,  0);
        repeat (3) @(negedge w_clk);

        // Asynchronous reset mid-RUN, then restart with load 1.
        t0 = cyc + 1;
        push(t0 + 4, 1, 0, 8'd4);
        do_start(8'd5, 1'b0);
        wait_until(t0 + 6);
        chk("pre_rst_count", r_count, 4);
        #10 w_rst = 1'b1;
        #1;
        chk("arst_count", r_count, 0);
        chk("arst_busy",  r_busy,  0);
        chk("arst_done",  r_done,  0);
        @(negedge w_clk);
        w_rst = 1'b0;
        repeat (2) @(negedge w_clk);
        t0 = cyc + 1;
        push(t0 + 4, 1, 1, 8'd0);
        do_start(8'd1, 1'b0);
        chk("restart_count", r_count, 1);
        wait_until(t0 + 5);
        chk("restart_idle",  r_busy,  0);
        repeat (4) @(negedge w_clk);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
